change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 Parameter GAP_TICKS, default 2: number of tick strobes between coin pulses (range 1..15).
REQ-002 Parameter TEN_STOCK, default 15: initial count of $10 coins (used only with CHANGE_INVENTORY_EN).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle pacing strobe; all coin spacing is counted in tick strobes.
REQ-006 req_valid  input  1  refund request present.
REQ-007 req_units  input  5  refund amount in $5 units (0..31).
REQ-008 req_ready  output  1  high only in IDLE; a request transfers on a cycle with req_valid && req_ready.
REQ-009 coin10  output  1  one-cycle pulse per $10 coin ejected.
REQ-010 coin5  output  1  one-cycle pulse per $5 coin ejected.
REQ-011 remaining  output  5  $5 units still owed; feeds the 7-seg BCD path.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse when a request completes.
REQ-014 refill  input  1  present only with CHANGE_INVENTORY_EN; reloads the $10 stock.

Function
REQ-015 FSM states: IDLE, DISPENSE, GAP, DONE.
REQ-016 IDLE: on handshake, capture req_units into remaining and go to DISPENSE on the next cycle.
REQ-017 DISPENSE, remaining>=2: pulse coin10 for one cycle, subtract 2 from remaining, go to GAP.
REQ-018 DISPENSE, remaining==1: pulse coin5 for one cycle, subtract 1 from remaining, go to GAP.
REQ-019 DISPENSE, remaining==0: go to DONE with no coin pulse.
REQ-020 GAP: count GAP_TICKS tick strobes, then return to DISPENSE; a tick on the GAP entry cycle counts.
REQ-021 DONE: pulse done for one cycle and return to IDLE.
REQ-022 A zero-unit request produces no coin pulse; done is asserted 2 cycles after the handshake.
REQ-023 Coin order is greedy: all $10 coins first, at most one trailing $5 coin.
REQ-024 coin10 and coin5 are never high in the same cycle.
REQ-025 req_valid is ignored while busy; there is no queuing.
REQ-026 remaining updates in the same cycle as the corresponding coin pulse.
REQ-027 All outputs are registered.

Reset
REQ-028 Reset asserted: state=IDLE, remaining=0, coin10=0, coin5=0, done=0, busy=0, GAP counter=0; req_ready=1 once reset is released.
REQ-029 Reset mid-dispense abandons the request immediately; no further pulses are produced after release.

Configuration
REQ-030 Macro CHANGE_INVENTORY_EN enables tracking of $10 coin stock.
REQ-031 With CHANGE_INVENTORY_EN defined:
- A 5-bit stock counter resets to TEN_STOCK and decrements on each coin10 pulse.
- A refill pulse reloads the stock to TEN_STOCK; if refill coincides with coin10, the reload wins.
- When stock==0, DISPENSE pays remaining>=2 as coin5 pulses (subtract 1 each) instead of coin10.
REQ-032 Without CHANGE_INVENTORY_EN: no refill port, no stock counter, and the greedy rule always applies.

Structure
REQ-033 Shared package holds:
- FSM state enum (IDLE, DISPENSE, GAP, DONE).
- Units width constant (5).
- Default GAP_TICKS and TEN_STOCK values.
REQ-034 One sub-module, tick_gap_counter, counts tick strobes and raises expire; the FSM stays in change_dispenser.
REQ-035 Instantiated downstream of ticketsystem_FSM; tick is derived from the clk25 rate.

Verification
REQ-036 req_units=7, GAP_TICKS=2 -> coin10 x3 then coin5 x1; remaining 7,5,3,1,0; one done pulse; no overlapping pulses.
REQ-037 req_units=0 -> no coin pulses; done exactly 2 cycles after handshake; req_ready back high the cycle after done.
REQ-038 req_valid held during dispense with req_units=9 -> request ignored; only the first request is paid.
REQ-039 Reset asserted after the second coin of a 6-unit request -> outputs zero immediately; no pulses after release; req_ready=1.
REQ-040 CHANGE_INVENTORY_EN, TEN_STOCK=1, req_units=4 -> coin10 x1, coin5 x2; then refill restores stock to 1.
REQ-041 tick held low during GAP -> no coin pulse until GAP_TICKS strobes are seen; busy stays 1 throughout.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared types and defaults for the coin change dispenser.
// CHANGE_INVENTORY_EN adds $10 stock tracking in the top level.
package change_dispenser_pkg;

  localparam int UNITS_W       = 5;
  localparam int GAP_W         = 4;
  localparam int GAP_TICKS_DEF = 2;
  localparam int TEN_STOCK_DEF = 15;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    GAP,
    DONE
  } state_e;

  function automatic logic pay_ten(
    input logic [UNITS_W-1:0] rem,
    input logic               ten_ok
  );
    return (rem >= UNITS_W'(2)) && ten_ok;
  endfunction

endpackage

// File: rtl/change_dispenser_tick_gap_counter.sv
// Counts tick strobes while enabled; expire fires on the last one.
// Cleared whenever disabled so every gap starts from zero.
module tick_gap_counter
  import change_dispenser_pkg::*;
#(
  parameter int GAP_TICKS = GAP_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_tick,
  output logic o_expire
);

  localparam logic [GAP_W-1:0] LAST = GAP_W'(GAP_TICKS - 1);

  logic [GAP_W-1:0] r_cnt;

  assign o_expire = i_en && i_tick && (r_cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_en || o_expire) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + GAP_W'(1);
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Greedy $10/$5 refund dispenser with tick-paced coin spacing.
// Define CHANGE_INVENTORY_EN to track $10 stock and add the refill port.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int GAP_TICKS = GAP_TICKS_DEF,
  parameter int TEN_STOCK = TEN_STOCK_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               req_valid,
  input  logic [UNITS_W-1:0] req_units,
`ifdef CHANGE_INVENTORY_EN
  input  logic               refill,
`endif
  output logic               req_ready,
  output logic               coin10,
  output logic               coin5,
  output logic [UNITS_W-1:0] remaining,
  output logic               busy,
  output logic               done
);

  if (GAP_TICKS < 1 || GAP_TICKS > 15) begin : g_bad_gap
    $error("GAP_TICKS must be within 1..15");
  end
  if (TEN_STOCK < 0 || TEN_STOCK > 31) begin : g_bad_stock
    $error("TEN_STOCK must be within 0..31");
  end

  state_e             r_state;
  state_e             w_next;
  logic [UNITS_W-1:0] r_rem;
  logic [UNITS_W-1:0] w_rem;
  logic               r_coin10;
  logic               r_coin5;
  logic               r_done;
  logic               r_busy;
  logic               r_ready;
  logic               w_c10;
  logic               w_c5;
  logic               w_expire;
  logic               w_ten_ok;

  tick_gap_counter #(
    .GAP_TICKS (GAP_TICKS)
  ) u_gap (
    .clk      (clk),
    .reset    (reset),
    .i_en     (r_state == GAP),
    .i_tick   (tick),
    .o_expire (w_expire)
  );

`ifdef CHANGE_INVENTORY_EN
  localparam logic [UNITS_W-1:0] STOCK_INIT = UNITS_W'(TEN_STOCK);

  logic [UNITS_W-1:0] r_stock;

  // Refill takes priority over a same-cycle $10 payout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stock <= STOCK_INIT;
    end else if (refill) begin
      r_stock <= STOCK_INIT;
    end else if (w_c10) begin
      r_stock <= r_stock - UNITS_W'(1);
    end
  end

  assign w_ten_ok = (r_stock != '0);
`else
  assign w_ten_ok = 1'b1;
`endif

  always_comb begin
    w_next = r_state;
    w_rem  = r_rem;
    w_c10  = 1'b0;
    w_c5   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (req_valid && r_ready) begin
          w_next = DISPENSE;
          w_rem  = req_units;
        end
      end
      DISPENSE: begin
        if (pay_ten(r_rem, w_ten_ok)) begin
          w_c10  = 1'b1;
          w_rem  = r_rem - UNITS_W'(2);
          w_next = GAP;
        end else if (r_rem != '0) begin
          w_c5   = 1'b1;
          w_rem  = r_rem - UNITS_W'(1);
          w_next = GAP;
        end else begin
          w_next = DONE;
        end
      end
      GAP: begin
        if (w_expire) begin
          w_next = DISPENSE;
        end
      end
      DONE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next-state decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_rem    <= '0;
      r_coin10 <= 1'b0;
      r_coin5  <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_rem    <= w_rem;
      r_coin10 <= w_c10;
      r_coin5  <= w_c5;
      r_done   <= (w_next == DONE);
      r_busy   <= (w_next != IDLE);
      r_ready  <= (w_next == IDLE);
    end
  end

  assign req_ready = r_ready;
  assign coin10    = r_coin10;
  assign coin5     = r_coin5;
  assign remaining = r_rem;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus queues expected
// coin/done events, a negedge monitor pops and compares them.
module tb_change_dispenser;

  localparam int GT = 2;
`ifdef CHANGE_INVENTORY_EN
  localparam int TS  = 1;
  localparam bit INV = 1'b1;
`else
  localparam int TS  = 15;
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       req_valid = 1'b0;
  logic [4:0] req_units = '0;
`ifdef CHANGE_INVENTORY_EN
  logic       refill = 1'b0;
`endif
  logic       req_ready;
  logic       coin10;
  logic       coin5;
  logic [4:0] remaining;
  logic       busy;
  logic       done;

  change_dispenser #(
    .GAP_TICKS (GT),
    .TEN_STOCK (TS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .req_valid (req_valid),
    .req_units (req_units),
`ifdef CHANGE_INVENTORY_EN
    .refill    (refill),
`endif
    .req_ready (req_ready),
    .coin10    (coin10),
    .coin5     (coin5),
    .remaining (remaining),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int kind;
    int rem;
  } ev_t;

  ev_t q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  bit  tick_en = 1'b1;
  int  m_stock = TS;
  int  tc = 0;
  ev_t mon_e;
  int  mon_k;

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tick = tick_en && (tc == 0);
      tc = (tc == 2) ? 0 : tc + 1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: sim time %0t reached, required earlier finish", $time);
    $fatal(1);
  end

  task automatic check(input bit ok, input string nm,
                       input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic void push_ev(input int k, input int r);
    ev_t e;
    e.kind = k;
    e.rem  = r;
    q.push_back(e);
  endfunction

  // Expected event list: 0 = coin10, 1 = coin5, 2 = done.
  function automatic void push_req(input int units);
    int r;
    r = units;
    while (r > 0) begin
      if (r >= 2 && (!INV || m_stock > 0)) begin
        r -= 2;
        if (INV) m_stock--;
        push_ev(0, r);
      end else begin
        r -= 1;
        push_ev(1, r);
      end
    end
    push_ev(2, 0);
  endfunction

  always @(negedge clk) begin
    if (!reset && (coin10 || coin5 || done)) begin
      check(!(coin10 && coin5), "overlap", int'(coin5), 0);
      mon_k = coin10 ? 0 : (coin5 ? 1 : 2);
      check(q.size() != 0, "unexpected_pulse", mon_k, -1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check(mon_k == mon_e.kind && int'(remaining) == mon_e.rem,
              "event kind*100+rem", mon_k * 100 + int'(remaining),
              mon_e.kind * 100 + mon_e.rem);
      end
    end
  end

  task automatic wait_ready();
    int b;
    b = 0;
    @(negedge clk);
    while (!req_ready && b < 300) begin
      @(negedge clk);
      b++;
    end
    check(req_ready, "ready_timeout", int'(req_ready), 1);
  endtask

  task automatic send(input int units);
    wait_ready();
    push_req(units);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_units = 5'(units);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    @(negedge clk);
    while ((q.size() != 0 || !req_ready) && b < 600) begin
      @(negedge clk);
      b++;
    end
    check(q.size() == 0 && req_ready, "drain", q.size(), 0);
  endtask

`ifdef CHANGE_INVENTORY_EN
  task automatic do_refill();
    @(posedge clk);
    #1;
    refill = 1'b1;
    @(posedge clk);
    #1;
    refill = 1'b0;
    m_stock = TS;
  endtask
`endif

  initial begin
    int b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(remaining == 0, "rst_remaining", int'(remaining), 0);
    check(!coin10 && !coin5, "rst_coins", int'({coin10, coin5}), 0);
    check(!done, "rst_done", int'(done), 0);
    check(!busy, "rst_busy", int'(busy), 0);
    #2;
    reset = 1'b0;
    @(negedge clk);
    check(req_ready, "rst_ready", int'(req_ready), 1);

    // 7 units: 10,10,10,5 with remaining 7,5,3,1,0
    send(7);
    @(negedge clk);
    check(remaining == 7, "capture7", int'(remaining), 7);
    check(busy, "busy7", int'(busy), 1);
    drain();

    // zero units: done two cycles after handshake
    wait_ready();
    push_req(0);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_units = 5'd0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check(!done, "zero_done_c1", int'(done), 0);
    @(negedge clk);
    check(done, "zero_done_c2", int'(done), 1);
    check(!req_ready, "zero_ready_c2", int'(req_ready), 0);
    @(negedge clk);
    check(req_ready, "zero_ready_c3", int'(req_ready), 1);
    check(!done, "zero_done_c3", int'(done), 0);
    drain();

    send(1);
    drain();
    send(2);
    drain();
    send(31);
    drain();

    // valid held with a new amount while busy must be ignored
    wait_ready();
    push_req(3);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_units = 5'd3;
    @(posedge clk);
    #1;
    req_units = 5'd9;
    b = 0;
    @(negedge clk);
    while (!done && b < 300) begin
      @(negedge clk);
      b++;
    end
    req_valid = 1'b0;
    check(done, "hold_done_seen", int'(done), 1);
    drain();
    repeat (30) @(negedge clk);
    check(!busy && q.size() == 0, "hold_no_second", int'(busy), 0);

    // tick held low: no further coin while in the gap
    tick_en = 1'b0;
    send(3);
    b = 0;
    @(negedge clk);
    while (!(coin10 || coin5) && b < 50) begin
      @(negedge clk);
      b++;
    end
    check(coin10 || coin5, "notick_first_coin", 0, 1);
    repeat (20) begin
      @(negedge clk);
      check(!coin10 && !coin5 && busy, "notick_gap",
            int'({coin10, coin5, busy}), 1);
    end
    tick_en = 1'b1;
    drain();

`ifdef CHANGE_INVENTORY_EN
    // one $10 in stock: 4 units pays 10,5,5 then refill restores it
    do_refill();
    send(4);
    drain();
    do_refill();
    send(2);
    drain();
`endif

    // reset after the second coin of a 6-unit request
    send(6);
    b = 0;
    @(negedge clk);
    while (!((coin10 || coin5) && remaining == 2) && b < 300) begin
      @(negedge clk);
      b++;
    end
    check(remaining == 2, "mid_rem_before_reset", int'(remaining), 2);
    #2;
    reset = 1'b1;
    #1;
    check(!coin10 && !coin5 && !done, "mid_rst_pulses",
          int'({coin10, coin5, done}), 0);
    check(remaining == 0, "mid_rst_remaining", int'(remaining), 0);
    check(!busy, "mid_rst_busy", int'(busy), 0);
    q.delete();
    m_stock = TS;
    @(negedge clk);
    #2;
    reset = 1'b0;
    repeat (25) @(negedge clk);
    check(req_ready, "post_rst_ready", int'(req_ready), 1);
    check(!busy, "post_rst_busy", int'(busy), 0);

    send(5);
    drain();

    check(q.size() == 0, "queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
